// File: rtl/mem_arbiter.sv
// N-master to 1-slave arbiter for the valid/ready memory bus.
// Fixed-priority or round-robin selection, the winning request is latched for
// the whole transaction, and an optional watchdog ends hung transactions with an error.
module mem_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned RR_MODE        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  localparam int unsigned IDX_W         = $clog2(NUM_MASTERS),
  localparam int unsigned STRB_W        = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_instr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [NUM_MASTERS-1:0]        m_error,
  output logic                          mem_valid,
  output logic                          mem_instr,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [STRB_W-1:0]             mem_wstrb,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic                          mem_ready,
  output logic                          busy,
  output logic [IDX_W-1:0]              grant_idx
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_instr_q, mem_instr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]         cnt_q, cnt_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  int unsigned         cand;
  logic                timeout;
  logic                done;

  // Winner search: from index 0 (fixed) or from the RR pointer with wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand = (RR_MODE != 0) ? (32'(rr_ptr_q) + k) % NUM_MASTERS : k;
      if (!win_found && m_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Watchdog fires in the last allowed BUSY cycle; a coincident mem_ready takes precedence.
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1)) && !mem_ready;

  // Next-state logic plus combinational completion outputs.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    done        = 1'b0;
    m_ready     = '0;
    m_error     = '0;
    m_rdata     = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StBusy;
          mem_valid_d = 1'b1;
          mem_instr_d = m_instr[win_idx];
          mem_addr_d  = m_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = m_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          mem_wstrb_d = m_wstrb[win_idx*STRB_W +: STRB_W];
          grant_d     = win_idx;
          cnt_d       = '0;
        end
      end
      StBusy: begin
        if (mem_ready) begin
          m_ready[grant_q] = 1'b1;
          m_rdata          = mem_rdata;
          done             = 1'b1;
        end else if (timeout) begin
          m_ready[grant_q] = 1'b1;
          m_error[grant_q] = 1'b1;
          done             = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (done) begin
          state_d     = StIdle;
          mem_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // A transaction abandoned by reset must not signal completion.
    if (rst) begin
      m_ready = '0;
      m_error = '0;
      m_rdata = '0;
    end
  end

  // State and latched-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = (state_q == StBusy);
  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a round-robin/watchdog instance checked every cycle against
// a transaction-level model, plus a fixed-priority instance with a zero-wait slave.
module tb_mem_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    m_valid, m_instr, m_ready, m_error;
  logic [N*32-1:0] m_addr, m_wdata;
  logic [N*4-1:0]  m_wstrb;
  logic [31:0]     m_rdata, mem_addr, mem_wdata, mem_rdata;
  logic            mem_valid, mem_instr, mem_ready, busy;
  logic [3:0]      mem_wstrb;
  logic [1:0]      grant_idx;

  logic [N-1:0]    fp_valid, fp_instr, fp_ready, fp_error;
  logic [N*32-1:0] fp_addr, fp_wdata;
  logic [N*4-1:0]  fp_wstrb;
  logic [31:0]     fp_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
  logic            fp_mem_valid, fp_mem_instr, fp_mem_ready, fp_busy;
  logic [3:0]      fp_mem_wstrb;
  logic [1:0]      fp_grant;

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(1),
                .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .m_error(m_error), .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy), .grant_idx(grant_idx)
  );

  mem_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RR_MODE(0),
                .TIMEOUT_CYCLES(0)) u_fp (
    .clk(clk), .rst(rst), .m_valid(fp_valid), .m_instr(fp_instr), .m_addr(fp_addr),
    .m_wdata(fp_wdata), .m_wstrb(fp_wstrb), .m_rdata(fp_rdata), .m_ready(fp_ready),
    .m_error(fp_error), .mem_valid(fp_mem_valid), .mem_instr(fp_mem_instr),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb),
    .mem_rdata(fp_mem_rdata), .mem_ready(fp_mem_ready), .busy(fp_busy), .grant_idx(fp_grant)
  );

  // Zero-wait slave for the fixed-priority instance.
  assign fp_mem_ready = fp_mem_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Master-side request state.
  logic [N-1:0] pend, hold;
  logic [31:0]  p_addr [N];
  logic [31:0]  p_wdata[N];
  logic [3:0]   p_wstrb[N];
  logic [N-1:0] p_instr;
  bit           rand_req, do_chk, fix_rd;
  logic [31:0]  fix_val;
  int           next_lat, lat_cur;

  // Transaction-level reference model.
  bit           mb;          // transaction outstanding
  int           mo;          // owner / last granted master
  int           mw;          // BUSY cycles already elapsed
  int           mp;          // next master to search from
  logic [31:0]  ma, mwd;
  logic [3:0]   ms;
  logic         mi;
  int           grants[$];
  int           errs, fp_done;
  logic [31:0]  last_rdata, last_mrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r);
    bit         comp, found;
    logic [3:0] e_ready, e_err;
    logic [31:0] e_rdata;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (hold[i] || (rand_req && $urandom_range(0, 3) == 0))) begin
        pend[i]    = 1'b1;
        p_addr[i]  = $urandom;
        p_wdata[i] = $urandom;
        p_wstrb[i] = 4'($urandom_range(0, 15));
        p_instr[i] = 1'($urandom_range(0, 1));
      end
      m_valid[i]          = pend[i];
      m_instr[i]          = p_instr[i];
      m_addr[i*32 +: 32]  = p_addr[i];
      m_wdata[i*32 +: 32] = p_wdata[i];
      m_wstrb[i*4 +: 4]   = p_wstrb[i];
    end
    mem_ready = mb && !r && (mw == lat_cur);
    mem_rdata = fix_rd ? fix_val : $urandom;
    #1;
    comp    = mb && !r && (mem_ready || mw == 7);
    e_ready = comp ? 4'(1 << mo) : 4'b0;
    e_err   = (comp && !mem_ready) ? 4'(1 << mo) : 4'b0;
    e_rdata = (comp && mem_ready) ? mem_rdata : 32'h0;
    if (do_chk) begin
      chk("busy", 32'(busy), 32'(mb));
      chk("mem_valid", 32'(mem_valid), 32'(mb));
      chk("grant_idx", 32'(grant_idx), 32'(mo));
      chk("m_ready", 32'(m_ready), 32'(e_ready));
      chk("m_error", 32'(m_error), 32'(e_err));
      chk("m_rdata", m_rdata, e_rdata);
      if (mb) begin
        chk("mem_addr", mem_addr, ma);
        chk("mem_wdata", mem_wdata, mwd);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(ms));
        chk("mem_instr", 32'(mem_instr), 32'(mi));
      end
      chk("fp_error", 32'(fp_error), 32'h0);
      if (fp_valid != 4'b0 && fp_ready != 4'b0) begin
        chk("fp_lowest_wins", 32'(fp_ready), 32'(fp_valid & (~fp_valid + 4'd1)));
        fp_done++;
      end
    end
    if (comp) begin
      last_rdata = m_rdata;
      last_mrd   = mem_rdata;
    end
    // Advance the model to the state after the coming clock edge.
    if (r) begin
      mb = 1'b0; mo = 0; mp = 0; mw = 0;
    end else if (mb) begin
      if (comp) begin
        grants.push_back(mo);
        if (!mem_ready) errs++;
        pend[mo] = 1'b0;
        mb = 1'b0;
        mp = (mo + 1) % N;
      end else begin
        mw++;
      end
    end else if (pend != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && pend[(mp + k) % N]) begin
          found = 1'b1;
          mo    = (mp + k) % N;
        end
      end
      ma = p_addr[mo]; mwd = p_wdata[mo]; ms = p_wstrb[mo]; mi = p_instr[mo];
      mb = 1'b1;
      mw = 0;
      lat_cur = (next_lat >= 0) ? next_lat : int'($urandom_range(0, 11));
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 80 && (n == 0 || mb || pend != '0); n++) tick(1'b0);
    tick(1'b0);
    chk("drain_idle", 32'(busy), 32'h0);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    pend[i] = 1'b1; p_addr[i] = a; p_wdata[i] = d; p_wstrb[i] = s; p_instr[i] = 1'b0;
  endtask

  initial begin
    int e4a[6];
    int e4b[4];
    int e0;
    e4a = '{0, 1, 2, 3, 0, 1};
    e4b = '{1, 3, 1, 3};
    rst = 1'b1; pend = '0; hold = '0; p_instr = '0; rand_req = 0; do_chk = 0; fix_rd = 0;
    fix_val = '0; next_lat = 0; lat_cur = 0; mb = 0; mo = 0; mw = 0; mp = 0;
    ma = '0; mwd = '0; ms = '0; mi = 1'b0; errs = 0; fp_done = 0;
    last_rdata = '0; last_mrd = '0;
    for (int i = 0; i < N; i++) begin
      p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0;
    end
    m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    fp_valid = 4'hF; fp_instr = '0; fp_addr = '0; fp_wdata = '0; fp_wstrb = '0;
    fp_mem_rdata = 32'h1234_5678;

    tick(1'b1);
    tick(1'b1);
    do_chk = 1;
    tick(1'b1);
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);

    // Basic read from master 1, slave answers after 3 BUSY cycles.
    set_req(1, 32'h0000_0100, 32'h0, 4'h0);
    next_lat = 3; fix_rd = 1; fix_val = 32'hDEAD_BEEF;
    drain();
    chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("t1_grant", 32'(grants[$]), 32'd1);
    fix_rd = 0;

    // Write pass-through from master 0.
    e0 = errs;
    set_req(0, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011);
    next_lat = 2;
    drain();
    chk("t2_no_error", 32'(errs), 32'(e0));
    chk("t2_grant", 32'(grants[$]), 32'd0);

    // Round-robin with all masters continuously requesting.
    tick(1'b1);
    grants.delete();
    hold = 4'hF; next_lat = 0;
    for (int n = 0; n < 100 && grants.size() < 6; n++) tick(1'b0);
    hold = '0;
    for (int i = 0; i < 6; i++) chk("t4_rr_all", 32'(grants.size() > i ? grants[i] : -1), 32'(e4a[i]));
    drain();

    // Round-robin with only masters 1 and 3 requesting.
    tick(1'b1);
    grants.delete();
    hold = 4'b1010;
    for (int n = 0; n < 100 && grants.size() < 4; n++) tick(1'b0);
    hold = '0;
    for (int i = 0; i < 4; i++) chk("t4_rr_13", 32'(grants.size() > i ? grants[i] : -1), 32'(e4b[i]));
    drain();

    // Watchdog: silent slave, then a slave answering in the last allowed cycle.
    e0 = errs;
    set_req(2, 32'h0000_3000, 32'h0, 4'h0);
    next_lat = 20;
    drain();
    chk("t5_timeout", 32'(errs), 32'(e0 + 1));
    set_req(3, 32'h0000_3004, 32'h0, 4'h0);
    next_lat = 7;
    drain();
    chk("t5_ready_wins", 32'(errs), 32'(e0 + 1));
    chk("t5_rdata", last_rdata, last_mrd);

    // Reset in the middle of a transaction.
    e0 = grants.size();
    set_req(0, 32'h0000_4000, 32'h0, 4'h0);
    next_lat = 20;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    pend[0] = 1'b0;
    set_req(2, 32'h0000_5000, 32'h0, 4'h0);
    next_lat = 1;
    tick(1'b0);
    chk("t6_after_rst_grants", 32'(grants.size()), 32'(e0));
    tick(1'b0);
    chk("t6_busy", 32'(busy), 32'h1);
    chk("t6_grant", 32'(grant_idx), 32'd2);
    drain();

    // Randomized traffic with random slave latency (some hit the watchdog).
    rand_req = 1; next_lat = -1;
    for (int n = 0; n < 1500; n++) tick(1'b0);
    rand_req = 0;
    drain();

    // Fixed priority with a different set of requesters.
    fp_valid = '0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    fp_valid = 4'b1100;
    for (int n = 0; n < 10; n++) tick(1'b0);
    chk("fp_completions_seen", 32'(fp_done > 10), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
